instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: packs instruction fields into 32-bit words, drops illegal
// encodings, and streams legal words through a small FIFO into instruction memory.
module instr_encoder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [31:0] BaseAddr,
    input  logic        InValid,
    output logic        InReady,
    input  logic        InLast,
    input  logic [3:0]  Cond,
    input  logic [1:0]  Op,
    input  logic [5:0]  Funct,
    input  logic [3:0]  Rn,
    input  logic [3:0]  Rd,
    input  logic [11:0] Src2,
    input  logic [23:0] Imm24,
    output logic        MemWE,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWD,
    input  logic        MemReady,
    output logic        Busy,
    output logic        Done,
    output logic [7:0]  ErrCount
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCEPT, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } fields_t;

    state_t        state, state_nxt;
    fields_t       fld;
    logic [31:0]   fifo_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   addr_q;
    logic [7:0]    err_q;

    logic [31:0]   word;
    logic          legal;
    logic          full, empty, in_rdy, xfer, enq, deq, mem_we, start_ok;

    assign fld = '{cond: Cond, op: Op, funct: Funct, rn: Rn, rd: Rd,
                   src2: Src2, imm24: Imm24};

    // Encode and legality check
    always_comb begin
        word  = {fld.cond, fld.op, fld.funct, fld.rn, fld.rd, fld.src2};
        legal = 1'b1;
        case (fld.op)
            2'b00: legal = fld.funct[4:1] inside {4'b0100, 4'b0010, 4'b0000, 4'b1100};
            2'b10: word  = {fld.cond, 2'b10, fld.funct[5:4], fld.imm24};
            2'b11: legal = fld.funct[4:1] inside {4'b0000, 4'b0001, 4'b0010, 4'b0011};
            default: ;
        endcase
    end

    // Handshakes are built from registered occupancy only: no pass-through when full.
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign in_rdy   = (state == ACCEPT) && !full;
    assign xfer     = InValid && in_rdy;
    assign enq      = xfer && legal;
    assign mem_we   = !empty && ((state == ACCEPT) || (state == DRAIN));
    assign deq      = mem_we && MemReady;
    assign start_ok = Start && ((state == IDLE) || (state == DONE));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ACCEPT;
            ACCEPT:  if (xfer && InLast) state_nxt = DRAIN;
            DRAIN:   if (empty) state_nxt = DONE;
            DONE:    if (start_ok) state_nxt = ACCEPT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            addr_q <= '0;
            err_q  <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
                addr_q <= BaseAddr;
                err_q  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + 1'b1;
                if (deq) begin
                    rd_ptr <= rd_ptr + 1'b1;
                    addr_q <= addr_q + 32'd4;
                end
                case ({enq, deq})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
                if (xfer && !legal && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
            end
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (enq) fifo_mem[wr_ptr] <= word;
    end

    assign InReady  = in_rdy;
    assign MemWE    = mem_we;
    assign MemAddr  = addr_q;
    assign MemWD    = mem_we ? fifo_mem[rd_ptr] : 32'd0;
    assign Busy     = (state == ACCEPT) || (state == DRAIN);
    assign Done     = (state == DONE);
    assign ErrCount = err_q;

endmodule
